// File: rtl/parse_unit.sv
`default_nettype none
// ============================================================================
// parse_unit : stage-1 parse; buffers fetch bundles, issues one field-split
//              instruction per cycle.
// Revision   : 1.0
// ============================================================================
module parse_unit #(
    parameter int DEPTH    = 4,
    parameter int ADDR_W   = 2,
    parameter int SKIP_NOP = 1
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              flushBack_i,
    input  logic              enable_i,
    input  logic [15:0]       pc_i,
    input  logic [59:0]       data_i,
    input  logic              stall_i,
    output logic              enable_o,
    output logic [15:0]       pc_o,
    output logic              slot_o,
    output logic              format_o,
    output logic              branch_o,
    output logic [6:0]        opcode_o,
    output logic [4:0]        primReg_o,
    output logic [4:0]        secReg_o,
    output logic [15:0]       imm_o,
    output logic [ADDR_W:0]   count_o,
    output logic              overflow_o
);

    localparam logic [0:0]      SLOT_A  = 1'b0;
    localparam logic [0:0]      SLOT_B  = 1'b1;
    localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W + 1)'(DEPTH);

    logic [15:0]       r_mem_pc   [DEPTH];
    logic [59:0]       r_mem_data [DEPTH];
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W:0]   r_count;
    logic [0:0]        r_state;

    logic [29:0] w_head_a;
    logic [29:0] w_head_b;
    logic [29:0] w_instr;
    logic        w_empty;
    logic        w_full;
    logic        w_issue;
    logic        w_skip_b;
    logic        w_pop;
    logic        w_push;
    logic        w_drop;

    assign w_head_a = r_mem_data[r_rd_ptr][59:30];
    assign w_head_b = r_mem_data[r_rd_ptr][29:0];
    assign w_instr  = (r_state == SLOT_A) ? w_head_a : w_head_b;
    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == c_DEPTH);

    // Issue only when running; flush wins over stall, reset wins over both.
    assign w_issue  = reset_i & ~flushBack_i & ~stall_i & ~w_empty;
    assign w_skip_b = (SKIP_NOP != 0) && (w_head_b == 30'd0);
    assign w_pop    = w_issue & ((r_state == SLOT_B) | w_skip_b);
    // A pop on a full FIFO frees the slot for this edge's push.
    assign w_push   = reset_i & enable_i & ~flushBack_i & (~w_full | w_pop);
    assign w_drop   = reset_i & enable_i & ~flushBack_i & w_full & ~w_pop;

    always_ff @(posedge clock_i) begin
        if (w_push) begin
            r_mem_pc[r_wr_ptr]   <= pc_i;
            r_mem_data[r_wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i || flushBack_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_state  <= SLOT_A;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (ADDR_W + 1)'(1);
                2'b01:   r_count <= r_count - (ADDR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_issue) begin
                r_state <= (r_state == SLOT_A && !w_skip_b) ? SLOT_B : SLOT_A;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            enable_o  <= 1'b0;
            pc_o      <= '0;
            slot_o    <= 1'b0;
            format_o  <= 1'b0;
            branch_o  <= 1'b0;
            opcode_o  <= '0;
            primReg_o <= '0;
            secReg_o  <= '0;
            imm_o     <= '0;
        end else if (flushBack_i) begin
            enable_o <= 1'b0;
        end else if (!stall_i) begin
            if (!w_empty) begin
                enable_o  <= 1'b1;
                pc_o      <= r_mem_pc[r_rd_ptr];
                slot_o    <= (r_state == SLOT_B);
                format_o  <= w_instr[29];
                branch_o  <= w_instr[28];
                opcode_o  <= w_instr[27:21];
                primReg_o <= w_instr[20:16];
                // Reg-imm carries an immediate; reg-reg carries a second source.
                secReg_o  <= w_instr[29] ? 5'd0 : w_instr[15:11];
                imm_o     <= w_instr[29] ? w_instr[15:0] : 16'd0;
            end else begin
                enable_o <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            overflow_o <= 1'b0;
        end else if (w_drop) begin
            overflow_o <= 1'b1;
        end
    end

    assign count_o = r_count;

endmodule
`default_nettype wire

// File: tb/tb_parse_unit.sv
`default_nettype none
// ============================================================================
// tb_parse_unit : directed and random stimulus against a queue-based model.
// Revision      : 1.0
// ============================================================================
module tb_parse_unit;

    localparam int DEPTH    = 4;
    localparam int ADDR_W   = 2;
    localparam int SKIP_NOP = 1;

    logic        clk = 1'b0;
    logic        rst_n, flush, en, stall;
    logic [15:0] pc;
    logic [59:0] data;
    logic        enable_o, slot_o, format_o, branch_o, overflow_o;
    logic [15:0] pc_o, imm_o;
    logic [6:0]  opcode_o;
    logic [4:0]  primReg_o, secReg_o;
    logic [ADDR_W:0] count_o;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    logic [75:0] q[$];
    bit          half;
    logic        e_en, e_slot, e_fmt, e_br, e_ovf;
    logic [15:0] e_pc, e_imm;
    logic [6:0]  e_op;
    logic [4:0]  e_pr, e_sr;

    parse_unit #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .SKIP_NOP(SKIP_NOP)) dut (
        .clock_i(clk), .reset_i(rst_n), .flushBack_i(flush), .enable_i(en),
        .pc_i(pc), .data_i(data), .stall_i(stall),
        .enable_o(enable_o), .pc_o(pc_o), .slot_o(slot_o), .format_o(format_o),
        .branch_o(branch_o), .opcode_o(opcode_o), .primReg_o(primReg_o),
        .secReg_o(secReg_o), .imm_o(imm_o), .count_o(count_o),
        .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_fields(input logic [29:0] ins);
        e_fmt = ((ins >> 29) & 30'd1) != 30'd0;
        e_br  = ((ins >> 28) & 30'd1) != 30'd0;
        e_op  = 7'((ins >> 21) & 30'h7f);
        e_pr  = 5'((ins >> 16) & 30'h1f);
        e_sr  = e_fmt ? 5'd0 : 5'((ins >> 11) & 30'h1f);
        e_imm = e_fmt ? 16'(ins & 30'hffff) : 16'd0;
    endtask

    task automatic model(input logic r, input logic f, input logic s, input logic e,
                         input logic [15:0] p, input logic [59:0] d);
        bit          popped;
        bit          was_full;
        logic [75:0] head;
        if (!r) begin
            q.delete(); half = 0;
            {e_en, e_slot, e_fmt, e_br, e_ovf} = '0;
            e_pc = '0; e_imm = '0; e_op = '0; e_pr = '0; e_sr = '0;
        end else if (f) begin
            q.delete(); half = 0; e_en = 1'b0;
        end else begin
            popped   = 0;
            was_full = (q.size() == DEPTH);
            if (!s) begin
                if (q.size() > 0) begin
                    head = q[0];
                    e_en = 1'b1;
                    e_pc = head[75:60];
                    if (!half) begin
                        set_fields(head[59:30]);
                        e_slot = 1'b0;
                        if (SKIP_NOP != 0 && head[29:0] == 30'd0) popped = 1;
                        else half = 1;
                    end else begin
                        set_fields(head[29:0]);
                        e_slot = 1'b1;
                        popped = 1;
                        half   = 0;
                    end
                end else begin
                    e_en = 1'b0;
                end
            end
            if (popped) void'(q.pop_front());
            if (e) begin
                if (!was_full || popped) q.push_back({p, d});
                else e_ovf = 1'b1;
            end
        end
    endtask

    task automatic compare_all();
        check("enable_o",   32'(enable_o),   32'(e_en));
        check("pc_o",       32'(pc_o),       32'(e_pc));
        check("slot_o",     32'(slot_o),     32'(e_slot));
        check("format_o",   32'(format_o),   32'(e_fmt));
        check("branch_o",   32'(branch_o),   32'(e_br));
        check("opcode_o",   32'(opcode_o),   32'(e_op));
        check("primReg_o",  32'(primReg_o),  32'(e_pr));
        check("secReg_o",   32'(secReg_o),   32'(e_sr));
        check("imm_o",      32'(imm_o),      32'(e_imm));
        check("count_o",    32'(count_o),    32'(q.size()));
        check("overflow_o", 32'(overflow_o), 32'(e_ovf));
    endtask

    task automatic step(input logic r, input logic f, input logic s, input logic e,
                        input logic [15:0] p, input logic [59:0] d);
        rst_n = r; flush = f; stall = s; en = e; pc = p; data = d;
        @(posedge clk);
        model(r, f, s, e, p, d);
        #1;
        compare_all();
    endtask

    initial begin
        logic [29:0] a, b;
        rst_n = 1'b0; flush = 1'b0; stall = 1'b0; en = 1'b0; pc = '0; data = '0;

        step(0, 0, 0, 0, 16'h0, 60'h0);
        step(0, 0, 0, 1, 16'h5, 60'h123);
        check("tp_reset_count", 32'(count_o), 32'd0);

        // Single bundle, two reg-imm instructions
        a = {1'b1, 1'b0, 7'h0A, 5'd1, 16'd5};
        b = {1'b1, 1'b0, 7'h0A, 5'd2, 16'd10};
        step(1, 0, 0, 1, 16'h0001, {a, b});
        step(1, 0, 0, 0, 16'h0, 60'h0);
        check("tp_a_en",  32'(enable_o), 32'd1);
        check("tp_a_imm", 32'(imm_o),    32'd5);
        check("tp_a_op",  32'(opcode_o), 32'h0A);
        step(1, 0, 0, 0, 16'h0, 60'h0);
        check("tp_b_slot", 32'(slot_o),    32'd1);
        check("tp_b_reg",  32'(primReg_o), 32'd2);
        check("tp_b_imm",  32'(imm_o),     32'd10);
        step(1, 0, 0, 0, 16'h0, 60'h0);
        check("tp_idle_en", 32'(enable_o), 32'd0);

        // Slot-B nop skipped
        a = {1'b1, 1'b0, 7'h0A, 5'd3, 16'd15};
        step(1, 0, 0, 1, 16'h0002, {a, 30'd0});
        step(1, 0, 0, 0, 16'h0, 60'h0);
        check("tp_nop_imm", 32'(imm_o), 32'd15);
        step(1, 0, 0, 0, 16'h0, 60'h0);
        check("tp_nop_skip", 32'(enable_o), 32'd0);

        // Reg-reg decode
        a = {1'b0, 1'b1, 7'h06, 5'd3, 5'd2, 11'h7FF};
        b = {1'b1, 1'b1, 7'h11, 5'd9, 16'hBEEF};
        step(1, 0, 0, 1, 16'h0003, {a, b});
        step(1, 0, 0, 0, 16'h0, 60'h0);
        check("tp_rr_sec", 32'(secReg_o), 32'd2);
        check("tp_rr_imm", 32'(imm_o),    32'd0);
        step(1, 0, 0, 0, 16'h0, 60'h0);
        step(1, 0, 0, 0, 16'h0, 60'h0);

        // Overflow under stall: PCs 0..4, PC 4 dropped
        for (int i = 0; i < 5; i++) begin
            a = 30'($urandom) | 30'h1; b = 30'($urandom) | 30'h1;
            step(1, 0, 1, 1, 16'(i), {a, b});
        end
        check("tp_ovf_count", 32'(count_o),    32'd4);
        check("tp_ovf_flag",  32'(overflow_o), 32'd1);
        for (int i = 0; i < 9; i++) step(1, 0, 0, 0, 16'h0, 60'h0);

        // Flush while slot B pending
        for (int i = 0; i < 3; i++) begin
            a = 30'($urandom) | 30'h1; b = 30'($urandom) | 30'h1;
            step(1, 0, 1, 1, 16'(16 + i), {a, b});
        end
        step(1, 0, 0, 0, 16'h0, 60'h0);
        step(1, 1, 0, 1, 16'h0020, {a, b});
        check("tp_flush_en",    32'(enable_o), 32'd0);
        check("tp_flush_count", 32'(count_o),  32'd0);
        step(1, 0, 0, 1, 16'h0030, {a, b});
        step(1, 0, 0, 0, 16'h0, 60'h0);
        check("tp_post_flush_pc",   32'(pc_o),   32'h0030);
        check("tp_post_flush_slot", 32'(slot_o), 32'd0);
        step(1, 0, 0, 0, 16'h0, 60'h0);

        // Reset mid-operation with overflow set and two bundles queued
        step(1, 0, 1, 1, 16'h0040, {a, b});
        step(1, 0, 1, 1, 16'h0041, {a, b});
        step(0, 1, 0, 1, 16'h0042, {a, b});
        check("tp_rst_ovf", 32'(overflow_o), 32'd0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic r, f, s, e;
            r = ($urandom_range(63) != 0);
            f = ($urandom_range(19) == 0);
            s = ($urandom_range(3) == 0);
            e = ($urandom_range(3) != 0);
            a = 30'($urandom);
            b = ($urandom_range(9) < 3) ? 30'd0 : 30'($urandom);
            step(r, f, s, e, 16'($urandom), {a, b});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
